mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one synchronous-read memory port between an instruction-fetch
// requester (0) and a data requester (1). Requester 1 normally wins. Requester
// 0 is forced through once it has been denied STARVE_LIMIT consecutive cycles.
// Responses return with a fixed one-cycle latency.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   req0_valid/_addr   : fetch request in
//   req0_ready         : fetch request accepted this cycle
//   req1_valid/_addr/_wdata/_we : data request in (we == 0 means load)
//   req1_ready         : data request accepted this cycle
//   mem_en/_addr/_wdata/_we : shared memory port out
//   mem_rdata          : memory read data (valid the cycle after mem_en)
//   grant_sel          : 2:1 mux select, sticky to 1 after a requester-1 grant
//   rsp0_valid, rsp1_valid, rsp_data : responses (rsp_data = mem_rdata)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_we,
    output logic        req1_ready,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata,
    output logic        grant_sel,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       grant_sel_q, grant_sel_d;
    logic       rsp0_valid_q, rsp1_valid_q;
    logic       gnt0, gnt1;

    // Grant decision depends only on the valids and the starvation count.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0_valid && (!req1_valid || starve_cnt_q == LIMIT)) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (!rst && req0_valid && !gnt0) begin
            starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
        end
    end

    // grant_sel is sticky: only a requester-1 grant moves it (to 1).
    always_comb begin
        grant_sel_d = grant_sel_q;
        if (rst) begin
            grant_sel_d = 1'b0;
        end else if (gnt1) begin
            grant_sel_d = 1'b1;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = '0;
        if (gnt0) begin
            mem_addr = req0_addr;
        end else if (gnt1) begin
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
            mem_we    = req1_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            grant_sel_q  <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            grant_sel_q  <= grant_sel_d;
            rsp0_valid_q <= gnt0;
            rsp1_valid_q <= gnt1;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign mem_en     = gnt0 | gnt1;
    assign grant_sel  = grant_sel_d;
    // Gate with rst so a response due in the reset cycle is dropped.
    assign rsp0_valid = rsp0_valid_q & ~rst;
    assign rsp1_valid = rsp1_valid_q & ~rst;
    assign rsp_data   = mem_rdata;

endmodule
